// File: rtl/moore_seq_pkg.sv
// rtl/moore_seq_pkg.sv - state types, default pattern and the KMP-style next-state function
package moore_seq_pkg;

   localparam int DEF_PAT_LEN = 4;
   localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

   typedef logic [$clog2(DEF_PAT_LEN+1)-1:0] state_t;

   // State value is the length of the longest matched prefix.
   typedef enum state_t {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_e;

   // pattern is zero-extended; its first-arriving bit sits at [pat_len-1].
   function automatic int next_state(input int pat_len, input logic [7:0] pattern,
                                     input int k, input logic b, input bit overlap);
      int base;
      int pre;
      int seq;
      int mask;
      int res;
      base = (k == pat_len && !overlap) ? 0 : k;
      pre  = int'(pattern) >> (pat_len - base);
      seq  = (pre << 1) | int'(b);
      res  = 0;
      // Ascending scan so the longest border wins.
      for (int j = 1; j <= pat_len; j++) begin
         mask = (1 << j) - 1;
         if (j <= base + 1 && (seq & mask) == ((int'(pattern) >> (pat_len - j)) & mask))
            res = j;
      end
      return res;
   endfunction

endpackage

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - Moore serial pattern detector; MOORE_SEQ_OVERLAP_EN enables overlapping matches
module moore_seq_detector
   import moore_seq_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic in,
   input  logic rst,
   output logic out
);

   localparam int SW = $clog2(PAT_LEN + 1);
`ifdef MOORE_SEQ_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   logic [SW-1:0] rom [PAT_LEN+1][2];
   logic [SW-1:0] state;
   logic [SW-1:0] nxt;

   for (genvar k = 0; k <= PAT_LEN; k++) begin : g_k
      for (genvar b = 0; b < 2; b++) begin : g_b
         localparam int NS = next_state(PAT_LEN, 8'(PATTERN), k, 1'(b), OVERLAP);
         assign rom[k][b] = SW'(NS);
      end
   end

   // Encodings above PAT_LEN fall through to S0.
   always_comb begin
      nxt = '0;
      for (int k = 0; k <= PAT_LEN; k++) begin
         if (state == SW'(k))
            nxt = rom[k][in];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SW'(S0);
         out   <= 1'b0;
      end else begin
         state <= nxt;
         out   <= (nxt == SW'(PAT_LEN));
      end
   end

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - randomized and directed checks of moore_seq_detector against a history model
module tb_moore_seq_detector;

`ifdef MOORE_SEQ_OVERLAP_EN
   localparam bit OV = 1'b1;
`else
   localparam bit OV = 1'b0;
`endif

   logic clk = 1'b0;
   logic in  = 1'b0;
   logic rst = 1'b1;
   logic out1;
   logic out2;

   int checks = 0;
   int errors = 0;

   int h1 = 0, h2 = 0;
   int since1 = 0, since2 = 0;
   logic m1 = 1'b0, m2 = 1'b0;

   always #5 clk = ~clk;

   moore_seq_detector dut1 (
      .clk(clk),
      .in (in),
      .rst(rst),
      .out(out1)
   );

   moore_seq_detector #(
      .PAT_LEN(3),
      .PATTERN(3'b010)
   ) dut2 (
      .clk(clk),
      .in (in),
      .rst(rst),
      .out(out2)
   );

   // Match when the last L bits received since reset (or, without overlap,
   // since the previous match) equal the pattern.
   task automatic mdl(input logic b, input logic r, input int l, input int pat,
                      inout int h, inout int since, output logic m);
      int mask;
      mask = (1 << l) - 1;
      if (r) begin
         h = 0;
         since = 0;
         m = 1'b0;
      end else begin
         h = ((h << 1) | int'(b)) & 'hff;
         since++;
         m = (since >= l) && ((h & mask) == pat);
         if (m && !OV)
            since = 0;
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // e1/e2: directed expectation for each instance, -1 means model only.
   task automatic step(input logic b, input logic r, input int e1, input int e2, input string tag);
      @(negedge clk);
      in  = b;
      rst = r;
      @(posedge clk);
      mdl(b, r, 4, 'b1101, h1, since1, m1);
      mdl(b, r, 3, 'b010, h2, since2, m2);
      #1;
      chk({tag, "_m4"}, out1, m1);
      chk({tag, "_m3"}, out2, m2);
      if (e1 >= 0) chk({tag, "_d4"}, out1, e1[0]);
      if (e2 >= 0) chk({tag, "_d3"}, out2, e2[0]);
   endtask

   initial begin
      int ovi;
      ovi = OV ? 1 : 0;

      step(1'b0, 1'b1, 0, 0, "rst0");
      step(1'b1, 1'b1, 0, 0, "rst1");
      step(1'b1, 1'b1, 0, 0, "rst2");

      step(1'b1, 1'b0, 0, -1, "a1");
      step(1'b1, 1'b0, 0, -1, "a2");
      step(1'b1, 1'b0, 0, -1, "a3");
      step(1'b0, 1'b0, 0, -1, "a4");
      step(1'b1, 1'b0, 1, -1, "a5");
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b0, 0, -1, "ones");

      step(1'b0, 1'b1, 0, 0, "rstb");
      step(1'b1, 1'b0, 0, -1, "b1");
      step(1'b1, 1'b0, 0, -1, "b2");
      step(1'b0, 1'b0, 0, -1, "b3");
      step(1'b1, 1'b0, 1, -1, "b4");
      step(1'b1, 1'b0, 0, -1, "b5");
      step(1'b0, 1'b0, 0, -1, "b6");
      step(1'b1, 1'b0, ovi, -1, "b7");

      step(1'b0, 1'b1, 0, 0, "rstc");
      step(1'b1, 1'b0, 0, -1, "c1");
      step(1'b1, 1'b0, 0, -1, "c2");
      step(1'b0, 1'b0, 0, -1, "c3");
      step(1'b1, 1'b1, 0, 0, "cmid");
      step(1'b1, 1'b0, 0, -1, "c4");
      step(1'b1, 1'b0, 0, -1, "c5");
      step(1'b0, 1'b0, 0, -1, "c6");
      step(1'b1, 1'b0, 1, -1, "c7");

      step(1'b0, 1'b1, 0, 0, "rstd");
      step(1'b0, 1'b0, -1, 0, "d1");
      step(1'b1, 1'b0, -1, 0, "d2");
      step(1'b0, 1'b0, -1, 1, "d3");
      step(1'b1, 1'b0, -1, 0, "d4");
      step(1'b0, 1'b0, -1, ovi, "d5");

      for (int i = 0; i < 400; i++)
         step(1'($urandom), ($urandom_range(0, 24) == 0), -1, -1, "rnd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
